// File: rtl/frame_sequencer.sv
// Top-level game control FSM: sequences init, idle, move, collide and draw phases
// off the datapath's done handshakes, with per-state watchdog and frame counter.
module frame_sequencer #(
    parameter int          INIT_CYCLES    = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd200000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pause,
    input  logic        idle_done,
    input  logic        gen_move_done,
    input  logic        check_collide_done,
    input  logic        draw_map_done,
    input  logic        draw_link_done,
    input  logic        draw_enemies_done,
    output logic        init,
    output logic        idle,
    output logic        gen_move,
    output logic        check_collide,
    output logic        apply_act_link,
    output logic        move_enemies,
    output logic        draw_map,
    output logic        draw_link,
    output logic        draw_enemies,
    output logic [3:0]  state,
    output logic [15:0] frame_count,
    output logic        timeout_error,
    output logic [3:0]  timeout_state
);

    typedef enum logic [3:0] {
        S_INIT          = 4'd0,
        S_IDLE          = 4'd1,
        S_GEN_MOVE      = 4'd2,
        S_CHECK_COLLIDE = 4'd3,
        S_APPLY_LINK    = 4'd4,
        S_MOVE_ENEMIES  = 4'd5,
        S_DRAW_MAP      = 4'd6,
        S_DRAW_LINK     = 4'd7,
        S_DRAW_ENEMIES  = 4'd8
    } state_t;

    localparam int                INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [23:0]       WAIT_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [23:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              timeout_error_q, timeout_error_d;
    logic [3:0]        timeout_state_q, timeout_state_d;

    logic   handshake;
    logic   done_sel;
    logic   done_valid;
    logic   wd_fire;
    state_t hs_next;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. wait_cnt_q is zero only on the entry cycle of a handshake
    // state, which is how a stale done left over from the previous frame is ignored.
    always_comb begin
        state_d   = state_q;
        handshake = 1'b0;
        done_sel  = 1'b0;
        hs_next   = S_INIT;
        case (state_q)
            S_INIT:          if (init_cnt_q == INIT_LAST) state_d = S_DRAW_MAP;
            S_IDLE:          if (idle_done && !pause) state_d = S_GEN_MOVE;
            S_GEN_MOVE:      begin handshake = 1'b1; done_sel = gen_move_done;      hs_next = S_CHECK_COLLIDE; end
            S_CHECK_COLLIDE: begin handshake = 1'b1; done_sel = check_collide_done; hs_next = S_APPLY_LINK;    end
            S_APPLY_LINK:    state_d = S_MOVE_ENEMIES;
            S_MOVE_ENEMIES:  state_d = S_DRAW_MAP;
            S_DRAW_MAP:      begin handshake = 1'b1; done_sel = draw_map_done;      hs_next = S_DRAW_LINK;     end
            S_DRAW_LINK:     begin handshake = 1'b1; done_sel = draw_link_done;     hs_next = S_DRAW_ENEMIES;  end
            S_DRAW_ENEMIES:  begin handshake = 1'b1; done_sel = draw_enemies_done;  hs_next = S_IDLE;          end
            default:         state_d = S_INIT;
        endcase
        done_valid = handshake && done_sel && (wait_cnt_q != 24'd0);
        wd_fire    = handshake && !done_valid && (wait_cnt_q == WAIT_LAST);
        if (done_valid || wd_fire) state_d = hs_next;
    end

    // Output decode (Moore): illegal codes drive no strobe
    always_comb begin
        init           = 1'b0;
        idle           = 1'b0;
        gen_move       = 1'b0;
        check_collide  = 1'b0;
        apply_act_link = 1'b0;
        move_enemies   = 1'b0;
        draw_map       = 1'b0;
        draw_link      = 1'b0;
        draw_enemies   = 1'b0;
        case (state_q)
            S_INIT:          init           = 1'b1;
            S_IDLE:          idle           = 1'b1;
            S_GEN_MOVE:      gen_move       = 1'b1;
            S_CHECK_COLLIDE: check_collide  = 1'b1;
            S_APPLY_LINK:    apply_act_link = 1'b1;
            S_MOVE_ENEMIES:  move_enemies   = 1'b1;
            S_DRAW_MAP:      draw_map       = 1'b1;
            S_DRAW_LINK:     draw_link      = 1'b1;
            S_DRAW_ENEMIES:  draw_enemies   = 1'b1;
            default:         ;
        endcase
    end

    always_comb begin
        init_cnt_d      = (state_q == S_INIT && state_d == S_INIT) ? init_cnt_q + 1'b1 : '0;
        wait_cnt_d      = (handshake && state_d == state_q) ? wait_cnt_q + 24'd1 : 24'd0;
        frame_count_d   = frame_count_q;
        timeout_error_d = timeout_error_q;
        timeout_state_d = timeout_state_q;
        if (state_q == S_DRAW_ENEMIES && state_d == S_IDLE) frame_count_d = frame_count_q + 16'd1;
        // Only the first timeout's state is kept; later ones just keep the flag set.
        if (wd_fire) begin
            timeout_error_d = 1'b1;
            if (!timeout_error_q) timeout_state_d = state_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            init_cnt_q      <= '0;
            wait_cnt_q      <= 24'd0;
            frame_count_q   <= 16'd0;
            timeout_error_q <= 1'b0;
            timeout_state_q <= 4'd0;
        end else begin
            init_cnt_q      <= init_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            frame_count_q   <= frame_count_d;
            timeout_error_q <= timeout_error_d;
            timeout_state_q <= timeout_state_d;
        end
    end

    assign state         = state_q;
    assign frame_count   = frame_count_q;
    assign timeout_error = timeout_error_q;
    assign timeout_state = timeout_state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: expected status words are queued per step
// and compared on the falling edge after each rising edge.
module tb_frame_sequencer;

    logic        clock;
    logic        reset;
    logic        pause;
    logic        idle_done;
    logic        gen_move_done;
    logic        check_collide_done;
    logic        draw_map_done;
    logic        draw_link_done;
    logic        draw_enemies_done;
    logic        init, idle, gen_move, check_collide, apply_act_link;
    logic        move_enemies, draw_map, draw_link, draw_enemies;
    logic [3:0]  state;
    logic [15:0] frame_count;
    logic        timeout_error;
    logic [3:0]  timeout_state;

    frame_sequencer #(
        .INIT_CYCLES    (4),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .pause              (pause),
        .idle_done          (idle_done),
        .gen_move_done      (gen_move_done),
        .check_collide_done (check_collide_done),
        .draw_map_done      (draw_map_done),
        .draw_link_done     (draw_link_done),
        .draw_enemies_done  (draw_enemies_done),
        .init               (init),
        .idle               (idle),
        .gen_move           (gen_move),
        .check_collide      (check_collide),
        .apply_act_link     (apply_act_link),
        .move_enemies       (move_enemies),
        .draw_map           (draw_map),
        .draw_link          (draw_link),
        .draw_enemies       (draw_enemies),
        .state              (state),
        .frame_count        (frame_count),
        .timeout_error      (timeout_error),
        .timeout_state      (timeout_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // {strobes[8:0], state[3:0], frame_count[15:0], timeout_error, timeout_state[3:0]}
    logic [33:0] exp_q[$];

    logic [15:0] exp_frame;
    logic        exp_terr;
    logic [3:0]  exp_tstate;
    logic [3:0]  prev_exp;

    function automatic logic [33:0] pack_exp(input logic [3:0] es);
        logic [8:0] strb;
        strb = (es < 4'd9) ? (9'b1 << es) : 9'b0;
        return {strb, es, exp_frame, exp_terr, exp_tstate};
    endfunction

    // scoreboard compare
    task automatic compare(input string tag);
        logic [33:0] obs;
        logic [33:0] e;
        obs = {draw_enemies, draw_link, draw_map, move_enemies, apply_act_link,
               check_collide, gen_move, idle, init,
               state, frame_count, timeout_error, timeout_state};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // driver: one clock, expected state after the edge
    task automatic tick(input string tag, input logic [3:0] es);
        if (prev_exp == 4'd8 && es == 4'd1) exp_frame = exp_frame + 16'd1;
        prev_exp = es;
        exp_q.push_back(pack_exp(es));
        @(posedge clock);
        @(negedge clock);
        compare(tag);
    endtask

    task automatic set_done(input logic [3:0] st, input logic v);
        case (st)
            4'd2: gen_move_done      = v;
            4'd3: check_collide_done = v;
            4'd6: draw_map_done      = v;
            4'd7: draw_link_done     = v;
            4'd8: draw_enemies_done  = v;
            default: idle_done       = v;
        endcase
    endtask

    // done pulsed on the 2nd cycle of the state
    task automatic hs(input string tag, input logic [3:0] cur, input logic [3:0] nxt);
        tick({tag, "_hold"}, cur);
        set_done(cur, 1'b1);
        tick({tag, "_adv"}, nxt);
        set_done(cur, 1'b0);
    endtask

    task automatic stall(input string tag, input logic [3:0] cur, input int n);
        for (int i = 0; i < n; i++) tick(tag, cur);
    endtask

    task automatic reset_model();
        exp_frame  = 16'd0;
        exp_terr   = 1'b0;
        exp_tstate = 4'd0;
        prev_exp   = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no finish expected=finish by 100000");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0;
        pause = 1'b0;
        idle_done = 1'b0;
        gen_move_done = 1'b0;
        check_collide_done = 1'b0;
        draw_map_done = 1'b0;
        draw_link_done = 1'b0;
        draw_enemies_done = 1'b0;
        reset_model();

        repeat (5) @(negedge clock);
        exp_q.push_back(pack_exp(4'd0));
        compare("reset_state");
        reset = 1'b1;

        stall("init_hold", 4'd0, 3);
        tick("init_exit", 4'd6);

        // frame 1: full sequence
        hs("draw_map1", 4'd6, 4'd7);
        hs("draw_link1", 4'd7, 4'd8);
        hs("draw_enemies1", 4'd8, 4'd1);
        hs("idle1", 4'd1, 4'd2);
        hs("gen_move1", 4'd2, 4'd3);
        hs("check_collide1", 4'd3, 4'd4);
        tick("apply_link1", 4'd5);
        tick("move_enemies1", 4'd6);

        // stale done held across DRAW_LINK entry
        tick("draw_map2_hold", 4'd6);
        draw_map_done = 1'b1;
        draw_link_done = 1'b1;
        tick("draw_map2_adv", 4'd7);
        draw_map_done = 1'b0;
        tick("draw_link_stale", 4'd7);
        tick("draw_link_adv", 4'd8);
        draw_link_done = 1'b0;
        hs("draw_enemies2", 4'd8, 4'd1);

        // done on the last watchdog cycle wins
        hs("idle2", 4'd1, 4'd2);
        stall("gen_move_wait", 4'd2, 15);
        gen_move_done = 1'b1;
        tick("gen_move_done_wins", 4'd3);
        gen_move_done = 1'b0;

        // CHECK_COLLIDE timeout
        stall("collide_wait", 4'd3, 15);
        exp_terr = 1'b1;
        exp_tstate = 4'd3;
        tick("collide_timeout", 4'd4);
        tick("apply_link3", 4'd5);
        tick("move_enemies3", 4'd6);

        // second timeout keeps the first state
        stall("draw_map_wait", 4'd6, 15);
        tick("draw_map_timeout", 4'd7);
        hs("draw_link3", 4'd7, 4'd8);
        hs("draw_enemies3", 4'd8, 4'd1);

        // pause holds IDLE and discards idle_done
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("pause_a", 4'd1);
            tick("pause_b", 4'd1);
            idle_done = 1'b1;
            tick("pause_tick", 4'd1);
            idle_done = 1'b0;
        end
        pause = 1'b0;
        tick("unpause_no_tick", 4'd1);
        idle_done = 1'b1;
        tick("unpause_go", 4'd2);
        idle_done = 1'b0;

        hs("gen_move4", 4'd2, 4'd3);
        hs("check_collide4", 4'd3, 4'd4);
        tick("apply_link4", 4'd5);
        tick("move_enemies4", 4'd6);
        tick("draw_map4", 4'd6);

        // asynchronous reset mid-draw
        #2 reset = 1'b0;
        #1;
        reset_model();
        exp_q.push_back(pack_exp(4'd0));
        compare("async_reset");
        @(negedge clock);
        exp_q.push_back(pack_exp(4'd0));
        compare("reset_held");
        reset = 1'b1;
        stall("reinit_hold", 4'd0, 3);
        tick("reinit_exit", 4'd6);
        hs("draw_map5", 4'd6, 4'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
